// File: rtl/trivium_stream_if.sv
// Config, control and data handshake bundle for trivium_stream_core.
interface trivium_stream_if #(
    parameter int unsigned W       = 8,
    parameter int unsigned LIMIT_W = 32
);
    logic               cfg_valid;
    logic               cfg_sel;
    logic [7:0]         cfg_data;
    logic               cfg_ready;
    logic               start;
    logic               abort;
    logic               din_valid;
    logic [W-1:0]       din;
    logic               din_ready;
    logic               dout_valid;
    logic [W-1:0]       dout;
    logic               dout_ready;
    logic [4:0]         status;
    logic [LIMIT_W-1:0] word_cnt;

    modport master (
        output cfg_valid, cfg_sel, cfg_data, start, abort, din_valid, din, dout_ready,
        input  cfg_ready, din_ready, dout_valid, dout, status, word_cnt
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_data, start, abort, din_valid, din, dout_ready,
        output cfg_ready, din_ready, dout_valid, dout, status, word_cnt
    );
endinterface

// File: rtl/trivium_stream_core.sv
// Trivium keystream engine and stream encryptor: byte-loaded key/IV, W cipher
// steps per clock, valid/ready data path and a per-key/IV output word limit.
module trivium_stream_core #(
    parameter int unsigned     W          = 8,
    parameter int unsigned     INIT_STEPS = 1152,
    parameter int unsigned     LIMIT_W    = 32,
    parameter longint unsigned MAX_WORDS  = 64'd4294967295
) (
    input  logic            clk,
    input  logic            rst,
    trivium_stream_if.slave bus
);
    localparam int unsigned        INIT_CYC   = INIT_STEPS / W;
    localparam int unsigned        STEP_W     = $clog2(INIT_CYC + 1);
    localparam logic [LIMIT_W-1:0] MAX_CNT    = LIMIT_W'(MAX_WORDS);
    localparam logic [3:0]         BYTES_FULL = 4'd10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_LIMIT = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [287:0]       s_q, s_d;
    logic [79:0]        key_q, key_d, iv_q, iv_d;
    logic [3:0]         key_cnt_q, key_cnt_d, iv_cnt_q, iv_cnt_d;
    logic               key_ok_q, key_ok_d, iv_ok_q, iv_ok_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [LIMIT_W-1:0] word_cnt_q, word_cnt_d;
    logic [W-1:0]       dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               cfg_err_q, cfg_err_d;

    logic               cfg_open_c, cfg_fire_c, din_ready_c, din_fire_c, dout_fire_c;
    logic [287:0]       s_adv_c, seed_c;
    logic [W-1:0]       ks_c;
    logic               t1_c, t2_c, t3_c;

    assign cfg_open_c  = (state_q == ST_IDLE) || (state_q == ST_LIMIT);
    assign cfg_fire_c  = bus.cfg_valid && cfg_open_c;
    assign din_ready_c = (state_q == ST_RUN) && (!dout_valid_q || bus.dout_ready);
    assign din_fire_c  = bus.din_valid && din_ready_c;
    assign dout_fire_c = dout_valid_q && bus.dout_ready;

    // W Trivium steps; s_q[i-1] holds s(i), earliest keystream bit lands in ks_c[W-1]
    always_comb begin
        s_adv_c = s_q;
        ks_c    = '0;
        t1_c    = 1'b0;
        t2_c    = 1'b0;
        t3_c    = 1'b0;
        for (int k = 0; k < W; k++) begin
            t1_c = s_adv_c[65] ^ s_adv_c[92];
            t2_c = s_adv_c[161] ^ s_adv_c[176];
            t3_c = s_adv_c[242] ^ s_adv_c[287];
            ks_c[W-1-k] = t1_c ^ t2_c ^ t3_c;
            t1_c = t1_c ^ (s_adv_c[90] & s_adv_c[91]) ^ s_adv_c[170];
            t2_c = t2_c ^ (s_adv_c[174] & s_adv_c[175]) ^ s_adv_c[263];
            t3_c = t3_c ^ (s_adv_c[285] & s_adv_c[286]) ^ s_adv_c[68];
            s_adv_c = {s_adv_c[286:177], t2_c, s_adv_c[175:93], t1_c, s_adv_c[91:0], t3_c};
        end
    end

    // Initial state: key_q/iv_q hold K1/IV1 in bit 79
    always_comb begin
        seed_c = '0;
        for (int i = 0; i < 80; i++) begin
            seed_c[i]      = key_q[79-i];
            seed_c[93 + i] = iv_q[79-i];
        end
        seed_c[287:285] = 3'b111;
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        key_d        = key_q;
        iv_d         = iv_q;
        key_cnt_d    = key_cnt_q;
        iv_cnt_d     = iv_cnt_q;
        key_ok_d     = key_ok_q;
        iv_ok_d      = iv_ok_q;
        step_d       = step_q;
        word_cnt_d   = word_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        cfg_err_d    = cfg_err_q;

        if (cfg_fire_c) begin
            if (bus.cfg_sel) begin
                iv_d = {iv_q[71:0], bus.cfg_data};
                if (iv_cnt_q != BYTES_FULL) iv_cnt_d = iv_cnt_q + 4'd1;
                if (iv_cnt_q >= BYTES_FULL - 4'd1) iv_ok_d = 1'b1;
            end else begin
                key_d = {key_q[71:0], bus.cfg_data};
                if (key_cnt_q != BYTES_FULL) key_cnt_d = key_cnt_q + 4'd1;
                if (key_cnt_q >= BYTES_FULL - 4'd1) key_ok_d = 1'b1;
            end
        end

        if (dout_fire_c) dout_valid_d = 1'b0;

        if (bus.abort) begin
            state_d      = ST_IDLE;
            s_d          = '0;
            dout_valid_d = 1'b0;
            word_cnt_d   = '0;
            step_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LIMIT: begin
                    if (bus.start) begin
                        if (key_ok_q && iv_ok_q) begin
                            s_d        = seed_c;
                            word_cnt_d = '0;
                            cfg_err_d  = 1'b0;
                            step_d     = '0;
                            state_d    = ST_INIT;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    s_d    = s_adv_c;
                    step_d = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(INIT_CYC - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (din_fire_c) begin
                        s_d          = s_adv_c;
                        dout_d       = bus.din ^ ks_c;
                        dout_valid_d = 1'b1;
                        word_cnt_d   = word_cnt_q + LIMIT_W'(1);
                        if (word_cnt_q + LIMIT_W'(1) == MAX_CNT) state_d = ST_LIMIT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            key_q        <= '0;
            iv_q         <= '0;
            key_cnt_q    <= '0;
            iv_cnt_q     <= '0;
            key_ok_q     <= 1'b0;
            iv_ok_q      <= 1'b0;
            step_q       <= '0;
            word_cnt_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            key_q        <= key_d;
            iv_q         <= iv_d;
            key_cnt_q    <= key_cnt_d;
            iv_cnt_q     <= iv_cnt_d;
            key_ok_q     <= key_ok_d;
            iv_ok_q      <= iv_ok_d;
            step_q       <= step_d;
            word_cnt_q   <= word_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.cfg_ready  = cfg_open_c;
    assign bus.din_ready  = din_ready_c;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.word_cnt   = word_cnt_q;
    assign bus.status     = {state_q == ST_LIMIT, cfg_err_q, state_q == ST_RUN,
                             state_q == ST_INIT, state_q == ST_IDLE};
endmodule

// File: tb/tb_trivium_stream_core.sv
// Scoreboard bench for trivium_stream_core (W=8, word limit 70): a bit-serial
// reference cipher predicts ciphertext, a negedge monitor checks every dout.
module tb_trivium_stream_core;
    localparam int unsigned MAXW = 70;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trivium_stream_if #(.W(8), .LIMIT_W(32)) bus();

    trivium_stream_core #(
        .W(8), .INIT_STEPS(1152), .LIMIT_W(32), .MAX_WORDS(64'd70)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] pt[8];
    bit         cap_en = 1'b0;
    bit         ms[1:288];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endfunction

    // Reference cipher, one bit per step, using the 1-based register naming
    function automatic bit mdl_step();
        bit t1, t2, t3, z;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        return z;
    endfunction

    function automatic void mdl_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[80-i];
            ms[93 + i] = v[80-i];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int i = 0; i < 1152; i++) void'(mdl_step());
    endfunction

    function automatic logic [7:0] mdl_byte();
        logic [7:0] r;
        for (int b = 7; b >= 0; b--) r[b] = mdl_step();
        return r;
    endfunction

    // Monitor: every dout transfer pops one expected word
    always @(negedge clk) begin
        if (rst && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dout_unexpected: got %0h expected none", bus.dout);
            end else begin
                chk("dout", 64'(bus.dout), 64'(exp_q.pop_front()));
            end
            if (cap_en && cap_q.size() < 8) cap_q.push_back(bus.dout);
        end
    end

    // All tasks start and end at posedge+1
    task automatic cfg(input logic sel, input logic [7:0] d);
        int n;
        n = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_data  = d;
        @(negedge clk);
        while (!bus.cfg_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.cfg_ready) note_fail("cfg_accept_timeout");
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_start(output int n);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.status[1] && n < 5000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input bit use_mdl, input logic [7:0] e);
        int n;
        n = 0;
        bus.din       = d;
        bus.din_valid = 1'b1;
        @(negedge clk);
        while (!bus.din_ready && n < 200) begin @(negedge clk); n++; end
        if (bus.din_ready) exp_q.push_back(use_mdl ? (d ^ mdl_byte()) : e);
        else note_fail("din_accept_timeout");
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [79:0] key_v, iv_v;
        int n, acc;
        bus.cfg_valid = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_data = 8'h00;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.din_valid = 1'b0; bus.din = 8'h00; bus.dout_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_status", 64'(bus.status), 64'b00001);
        chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        chk("rst_din_ready", 64'(bus.din_ready), 64'd0);
        chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
        @(posedge clk); #1;

        // All-zero key and IV, 64 zero words
        key_v = '0; iv_v = '0;
        for (int i = 0; i < 10; i++) cfg(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) cfg(1'b1, 8'h00);
        mdl_load(key_v, iv_v);
        do_start(n);
        chk("init_len", 64'(n), 64'd144);
        chk("run_status", 64'(bus.status), 64'b00100);
        for (int i = 0; i < 64; i++) send(8'h00, 1'b1, 8'h00);
        drain();
        chk("word_cnt_64", 64'(bus.word_cnt), 64'd64);

        // Backpressure: one word buffered, din blocked for 5 cycles
        bus.dout_ready = 1'b0;
        send(8'h5A, 1'b1, 8'h00);
        bus.din = 8'hA5; bus.din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_din_ready", 64'(bus.din_ready), 64'd0);
            chk("bp_dout_valid", 64'(bus.dout_valid), 64'd1);
            @(posedge clk); #1;
        end
        chk("bp_word_cnt", 64'(bus.word_cnt), 64'd65);
        bus.dout_ready = 1'b1;
        send(8'hA5, 1'b1, 8'h00);
        drain();
        chk("bp_word_cnt_after", 64'(bus.word_cnt), 64'd66);

        // Abort while a word is held under backpressure
        bus.dout_ready = 1'b0;
        send(8'h3C, 1'b1, 8'h00);
        bus.din = 8'hC3; bus.din_valid = 1'b1;
        bus.abort = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        bus.abort = 1'b0; bus.din_valid = 1'b0;
        @(negedge clk);
        chk("abort_status", 64'(bus.status), 64'b00001);
        chk("abort_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("abort_word_cnt", 64'(bus.word_cnt), 64'd0);
        @(posedge clk); #1;
        bus.dout_ready = 1'b1;
        mdl_load(key_v, iv_v);
        do_start(n);
        chk("abort_restart_init", 64'(n), 64'd144);
        for (int i = 0; i < 8; i++) send(8'(i * 17), 1'b1, 8'h00);
        drain();

        // Asynchronous reset mid-run clears everything including key/IV
        bus.dout_ready = 1'b0;
        send(8'h77, 1'b1, 8'h00);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_status", 64'(bus.status), 64'b00001);
        chk("arst_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("arst_word_cnt", 64'(bus.word_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.dout_ready = 1'b1;

        // Nine key bytes only: start refused
        key_v = 80'h0123_4567_89AB_CDEF_0011;
        iv_v  = 80'hFEDC_BA98_7654_3210_0F0E;
        for (int i = 0; i < 9; i++) cfg(1'b0, key_v[79 - 8*i -: 8]);
        for (int i = 0; i < 10; i++) cfg(1'b1, iv_v[79 - 8*i -: 8]);
        do_start(n);
        chk("cfgerr_init_len", 64'(n), 64'd0);
        chk("cfgerr_status", 64'(bus.status), 64'b01001);
        cfg(1'b0, key_v[7:0]);
        mdl_load(key_v, iv_v);
        do_start(n);
        chk("cfgok_init_len", 64'(n), 64'd144);
        chk("cfgok_status", 64'(bus.status), 64'b00100);

        // Stream to the word limit, capturing the first 8 ciphertexts
        for (int i = 0; i < 8; i++) pt[i] = 8'(i * 37 + 5);
        cap_en = 1'b1;
        for (int i = 0; i < int'(MAXW); i++) send(8'(i * 37 + 5), 1'b1, 8'h00);
        @(negedge clk);
        chk("limit_status", 64'(bus.status), 64'b10000);
        chk("limit_din_ready", 64'(bus.din_ready), 64'd0);
        chk("limit_word_cnt", 64'(bus.word_cnt), 64'(MAXW));
        chk("limit_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        @(posedge clk); #1;
        acc = 0;
        bus.din = 8'hEE; bus.din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.din_ready) acc++;
        end
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        chk("limit_blocked", 64'(acc), 64'd0);
        drain();
        cap_en = 1'b0;
        chk("cap_count", 64'(cap_q.size()), 64'd8);
        chk("limit_dout_valid", 64'(bus.dout_valid), 64'd0);

        // Restart from LIMIT reproduces the same ciphertext for the same plaintext
        do_start(n);
        chk("limit_restart_init", 64'(n), 64'd144);
        for (int i = 0; i < 8; i++) send(pt[i], 1'b0, cap_q[i]);
        drain();

        // Feeding ciphertext back after restart recovers the plaintext
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        do_start(n);
        for (int i = 0; i < 8; i++) send(cap_q[i], 1'b0, pt[i]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trivium_stream_core.md
Name: trivium_stream_core

Overview:
Parametrised Trivium keystream engine and encryptor, the next generation of the team's serial-key Trivium block.
- Key and IV are both loaded as bytes over a config port; the IV is no longer fixed.
- Advances W cipher steps per clock and XORs W data bits per handshake.
- Uses valid/ready on data in and data out, and enforces a keystream-usage limit.
- Sits between the host config interface and the data FIFO path.

Parameters:
W, 8, keystream/data bits per handshake; legal values 1, 2, 4, 8, 16, 32, 64.
INIT_STEPS, 1152, warm-up cipher steps; must be a multiple of W.
LIMIT_W, 32, width of the output-word counter.
MAX_WORDS, 2**32-1, words emitted per key/IV before entering LIMIT.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_valid  in  1  config byte valid
cfg_sel  in  1  0 = key byte, 1 = IV byte
cfg_data  in  8  config byte; first byte carries K1/IV1 in bit 7
cfg_ready  out  1  config byte accepted when cfg_valid && cfg_ready
start  in  1  one-cycle pulse: begin init with loaded key/IV
abort  in  1  synchronous return to IDLE
din_valid  in  1  plaintext word valid
din  in  W  plaintext word; bit W-1 is XORed with the earliest keystream bit
din_ready  out  1  plaintext accepted
dout_valid  out  1  ciphertext valid
dout  out  W  ciphertext word
dout_ready  in  1  downstream accepts dout
status  out  5  {limit, cfg_err, run, init, idle}, one-hot except cfg_err
word_cnt  out  LIMIT_W  words emitted since last start

Behaviour:
- Reset values: state IDLE; s[1:288], key/IV byte counters and flags, word_cnt, dout, dout_valid, cfg_err all 0. Outputs after reset: cfg_ready=1, din_ready=0, status=5'b00001.
- State machine: IDLE, INIT, RUN, LIMIT.
- Config loading:
  - cfg_ready=1 only in IDLE and LIMIT.
  - Each key byte shifts into an 80-bit key register, MSB first; a 4-bit key counter saturates at 10 and sets key_ok at 10. The IV uses an identical register, counter and iv_ok flag.
  - An 11th or later byte of either kind shifts in; the oldest byte is lost and the flag stays set.
- start:
  - In IDLE or LIMIT with key_ok && iv_ok: load s1..s80=K1..K80, s81..s93=0, s94..s173=IV1..IV80, s174..s285=0, s286..s288=1. Clear word_cnt and cfg_err, go to INIT.
  - start without both flags: cfg_err=1, state unchanged.
  - start in INIT/RUN: ignored.
- INIT:
  - Each cycle, apply W standard Trivium steps with the output discarded (t1=s66^s93^s91&s92^s171; t2=s162^s177^s175&s176^s264; t3=s243^s288^s286&s287^s69; shift in t3/t1/t2).
  - A step counter reaches INIT_STEPS/W, then go to RUN. For W=8, INIT lasts exactly 144 cycles.
- RUN:
  - din_ready = !dout_valid || dout_ready.
  - On din handshake: dout <= din ^ z[W], dout_valid <= 1, cipher advances W steps, word_cnt += 1. Latency is 1 clock; full throughput is one word per clock with dout_ready held high.
  - dout_valid clears on dout handshake with no new din handshake.
  - When a handshake makes word_cnt reach MAX_WORDS, go to LIMIT at the next edge. The final dout stays valid until consumed.
- LIMIT: din_ready=0; keystream frozen; the config port is open. A new start with valid flags re-initialises and keeps the previously loaded key/IV if no new bytes were written.
- abort:
  - Any state goes to IDLE the next cycle.
  - s, dout_valid and word_cnt cleared.
  - Key/IV registers and flags kept.
  - abort has priority over start and handshakes in the same cycle.
- Simultaneous start and cfg_valid in IDLE: the config byte is written first, and start uses the flags before this byte.
- Async reset mid-operation: all state returns to reset values, including key/IV.

Test Plan:
- Key=0, IV=0, W=8: start, then 64 din=0x00 words → 64 dout bytes equal the team golden C model stream; INIT lasts 144 cycles (status.init high exactly 144 cycles).
- Same key/IV with W=1 and W=64 builds, same plaintext → bitwise-identical ciphertext stream to the W=8 build; decrypt by feeding ciphertext back after restart → original plaintext.
- Backpressure: dout_ready low for 5 cycles while din_valid held high → exactly one word buffered, din_ready=0 for those cycles, no word lost or duplicated, word_cnt increments once.
- Only 9 key bytes plus 10 IV bytes, then start → cfg_err=1, state stays IDLE; 10th key byte then start → cfg_err cleared, INIT entered.
- MAX_WORDS=4: stream 5 words → 4 douts, then status.limit=1, din_ready=0; restart with start → fresh keystream equal to the first.
- abort in RUN mid-backpressure → IDLE next cycle, dout_valid=0, word_cnt=0; immediate start reproduces the same keystream from word 0.
